// File: rtl/csa_operand_collector.sv
// Packs a stream of N-bit operands into zero-padded (x, y, z) triples for the carry-save adder.
// Two-deep: a collector feeds an output stage one edge after it fills; in_ready drops only when both are full and out_ready is low.
module csa_operand_collector #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] x,
   output logic [N-1:0] y,
   output logic [N-1:0] z,
   output logic [1:0]   out_count,
   output logic         out_last,
   output logic [15:0]  group_idx
);

   logic [N-1:0] c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         cfull_q, cfull_d, clast_q, clast_d;

   logic [N-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
   logic [1:0]   out_count_q, out_count_d;
   logic         out_last_q, out_last_d, out_valid_q, out_valid_d;
   logic [15:0]  group_idx_q, group_idx_d;

   logic         in_fire, out_fire, out_free, xfer;
   logic [1:0]   slot;

   assign out_free = ~out_valid_q | out_ready;
   assign in_ready = ~cfull_q | out_free;
   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid_q & out_ready;
   assign xfer     = cfull_q & out_free;

   always_comb begin
      c0_d    = c0_q;
      c1_d    = c1_q;
      c2_d    = c2_q;
      cnt_d   = cnt_q;
      cfull_d = cfull_q;
      clast_d = clast_q;
      slot    = 2'd0;
      if (xfer) begin
         c0_d    = '0;
         c1_d    = '0;
         c2_d    = '0;
         cnt_d   = 2'd0;
         cfull_d = 1'b0;
         clast_d = 1'b0;
      end
      // A transfer empties the collector this edge, so the new operand starts a fresh group.
      if (in_fire) begin
         slot = xfer ? 2'd0 : cnt_q;
         case (slot)
            2'd0:    c0_d = in_data;
            2'd1:    c1_d = in_data;
            default: c2_d = in_data;
         endcase
         cnt_d = slot + 2'd1;
         if (cnt_d == 2'd3 || in_last) begin
            cfull_d = 1'b1;
            clast_d = in_last;
         end
      end
   end

   always_comb begin
      x_d         = x_q;
      y_d         = y_q;
      z_d         = z_q;
      out_count_d = out_count_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;
      group_idx_d = group_idx_q;
      if (xfer) begin
         x_d         = c0_q;
         y_d         = c1_q;
         z_d         = c2_q;
         out_count_d = cnt_q;
         out_last_d  = clast_q;
         out_valid_d = 1'b1;
      end else if (out_fire) begin
         out_valid_d = 1'b0;
      end
      // Index tracks the triple being presented; it advances only when that triple is consumed.
      if (out_fire) begin
         group_idx_d = out_last_q ? 16'd0 : group_idx_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c0_q        <= '0;
         c1_q        <= '0;
         c2_q        <= '0;
         cnt_q       <= 2'd0;
         cfull_q     <= 1'b0;
         clast_q     <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         out_count_q <= 2'd0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
         group_idx_q <= 16'd0;
      end else begin
         c0_q        <= c0_d;
         c1_q        <= c1_d;
         c2_q        <= c2_d;
         cnt_q       <= cnt_d;
         cfull_q     <= cfull_d;
         clast_q     <= clast_d;
         x_q         <= x_d;
         y_q         <= y_d;
         z_q         <= z_d;
         out_count_q <= out_count_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
         group_idx_q <= group_idx_d;
      end
   end

   assign x         = x_q;
   assign y         = y_q;
   assign z         = z_q;
   assign out_count = out_count_q;
   assign out_last  = out_last_q;
   assign out_valid = out_valid_q;
   assign group_idx = group_idx_q;

endmodule

// File: tb/tb_csa_operand_collector.sv
// Scoreboarded bench for csa_operand_collector: directed operand streams, expected triples queued by hand.
module tb_csa_operand_collector;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_last;
   logic [31:0] in_data;
   logic        out_valid, out_ready, out_last;
   logic [31:0] x, y, z;
   logic [1:0]  out_count;
   logic [15:0] group_idx;

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] z;
      logic [1:0]  cnt;
      logic        last;
      logic [15:0] gidx;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int errors = 0;
   int ncyc = 0, acc_cnt = 0, acc3_cyc = -1, vld_cyc = -1, stall_cnt = 0;

   csa_operand_collector #(.N(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .x(x), .y(y), .z(z), .out_count(out_count), .out_last(out_last), .group_idx(group_idx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic void expect_t(input logic [31:0] ex, input logic [31:0] ey, input logic [31:0] ez,
                                    input logic [1:0] ec, input logic el, input logic [15:0] eg);
      exp_t e;
      e.x = ex; e.y = ey; e.z = ez; e.cnt = ec; e.last = el; e.gidx = eg;
      exp_q.push_back(e);
   endfunction

   // Monitor: pops one expected triple per consumed output.
   always @(negedge clk) begin
      exp_t got;
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         got.x = x; got.y = y; got.z = z; got.cnt = out_count; got.last = out_last; got.gidx = group_idx;
         if (exp_q.size() == 0) begin
            chk("unexpected_triple", {13'd0, got}, 128'd0);
         end else begin
            e = exp_q.pop_front();
            chk("triple", {13'd0, got}, {13'd0, e});
         end
      end
   end

   // Activity bookkeeping, sampled on the falling edge ahead of the edge that acts on it.
   always @(negedge clk) begin
      ncyc++;
      if (rst_n && in_valid && in_ready) begin
         acc_cnt++;
         if (acc_cnt == 3) acc3_cyc = ncyc;
      end
      if (rst_n && out_valid && vld_cyc < 0) vld_cyc = ncyc;
      if (rst_n && in_valid && !in_ready) stall_cnt++;
   end

   task automatic clear_stats();
      acc_cnt = 0; acc3_cyc = -1; vld_cyc = -1; stall_cnt = 0;
   endtask

   task automatic send(input logic [31:0] d, input logic l);
      bit fired = 1'b0;
      in_valid = 1'b1; in_data = d; in_last = l;
      for (int i = 0; i < 200 && !fired; i++) begin
         @(negedge clk);
         fired = in_ready;
         @(posedge clk);
         #1;
      end
      if (!fired) chk("send_accept", 128'(fired), 128'd1);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(posedge clk);
         #1;
         done = (exp_q.size() == 0) && !out_valid;
      end
      chk("drain_queue_empty", 128'(exp_q.size()), 128'd0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1 clear_stats();
   endtask

   task automatic check_outputs_zero(input string name);
      chk(name, {out_valid, x, y, z, out_count, out_last, group_idx}, 128'd0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
      #3 check_outputs_zero("reset_outputs_initial");
      chk("reset_in_ready_initial", 128'(in_ready), 128'd1);
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1 clear_stats();

      // Reset mid-group with a triple held on the output.
      send(32'd1, 0); send(32'd2, 0); send(32'd3, 0); send(32'd4, 0); send(32'd5, 0);
      chk("pre_reset_out_valid", 128'(out_valid), 128'd1);
      #1 rst_n = 1'b0;
      #1 check_outputs_zero("reset_outputs_async");
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      #1 chk("post_reset_in_ready", 128'(in_ready), 128'd1);
      out_ready = 1'b1;
      expect_t(32'h5, 32'h0, 32'h0, 2'd1, 1'b1, 16'd0);
      send(32'h5, 1);
      drain();

      // Steady stream.
      do_reset();
      out_ready = 1'b1;
      expect_t(32'd1, 32'd2, 32'd3, 2'd3, 1'b0, 16'd0);
      expect_t(32'd4, 32'd5, 32'd6, 2'd3, 1'b0, 16'd1);
      for (int i = 1; i <= 6; i++) send(32'(i), 0);
      drain();
      chk("steady_latency", 128'(vld_cyc - acc3_cyc), 128'd2);
      chk("steady_no_stall", 128'(stall_cnt), 128'd0);

      // Short group closed by in_last.
      do_reset();
      expect_t(32'hFFFF_FFFF, 32'h1, 32'h0, 2'd2, 1'b1, 16'd0);
      send(32'hFFFF_FFFF, 0); send(32'h1, 1);
      drain();
      chk("short_gidx_after", 128'(group_idx), 128'd0);

      // Backpressure: two groups fill, the seventh operand waits.
      do_reset();
      out_ready = 1'b0;
      expect_t(32'd1, 32'd2, 32'd3, 2'd3, 1'b0, 16'd0);
      expect_t(32'd4, 32'd5, 32'd6, 2'd3, 1'b0, 16'd1);
      expect_t(32'd7, 32'd8, 32'd9, 2'd3, 1'b0, 16'd2);
      fork
         begin
            for (int i = 1; i <= 9; i++) send(32'(i), 0);
         end
         begin
            bit reached = 1'b0;
            for (int i = 0; i < 100 && !reached; i++) begin
               @(posedge clk);
               #1 reached = (acc_cnt >= 6);
            end
            chk("bp_six_accepted", 128'(acc_cnt), 128'd6);
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               chk("bp_in_ready_low", 128'(in_ready), 128'd0);
               chk("bp_first_triple_held", {out_valid, x, y, z, out_count},
                   {1'b1, 32'd1, 32'd2, 32'd3, 2'd3});
            end
            chk("bp_seventh_held", 128'(acc_cnt), 128'd6);
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      // Single-operand packet.
      do_reset();
      expect_t(32'h7, 32'h0, 32'h0, 2'd1, 1'b1, 16'd0);
      send(32'h7, 1);
      drain();

      // group_idx counts triples within a packet.
      do_reset();
      for (int g = 0; g < 4; g++)
         expect_t(32'(3*g+1), 32'(3*g+2), 32'(3*g+3), 2'd3, 1'b0, 16'(g));
      expect_t(32'd13, 32'h0, 32'h0, 2'd1, 1'b1, 16'd4);
      for (int i = 1; i <= 12; i++) send(32'(i), 0);
      send(32'd13, 1);
      drain();
      chk("gidx_after_last", 128'(group_idx), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
